// File: rtl/pipeline_memwb_stage.sv
// MEM/WB pipeline register with valid/ready handshake, flush, and a saturating stall counter.
// Optional one-entry skid buffer in front of the output register: define MEMWB_SKID_EN.
module pipeline_memwb_stage #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned RA_W   = 2,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_dm,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [RA_W-1:0]   in_ra,
   input  logic              in_wb_sel,
   input  logic              in_data_sel,
   input  logic              in_reg_en,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_dm,
   output logic [DATA_W-1:0] out_alu,
   output logic [RA_W-1:0]   out_ra,
   output logic              out_wb_sel,
   output logic              out_data_sel,
   output logic              out_reg_en,
   output logic [DATA_W-1:0] out_wb_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef struct packed {
      logic [DATA_W-1:0] dm;
      logic [DATA_W-1:0] alu;
      logic [RA_W-1:0]   ra;
      logic              wb_sel;
      logic              data_sel;
      logic              reg_en;
   } beat_t;

   beat_t in_beat;
   beat_t out_beat;
   beat_t src_beat;
   logic  src_valid;
   logic  load;
   logic  accept;

   assign in_beat = {in_dm, in_alu, in_ra, in_wb_sel, in_data_sel, in_reg_en};

   // Output register may take a new beat when empty or draining this cycle.
   assign load = !out_valid || out_ready;

`ifdef MEMWB_SKID_EN
   beat_t skid_beat;
   logic  skid_valid;
   logic  ready_q;

   assign in_ready = ready_q;
   assign accept   = in_valid && ready_q;

   // A parked skid beat always wins the output slot; in_ready is low while it is parked.
   always_comb begin
      src_beat  = in_beat;
      src_valid = accept;
      if (skid_valid) begin
         src_beat  = skid_beat;
         src_valid = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         skid_valid <= 1'b0;
         skid_beat  <= '0;
         ready_q    <= 1'b1;
      end else if (flush || load) begin
         skid_valid <= 1'b0;
         ready_q    <= 1'b1;
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_beat  <= in_beat;
         ready_q    <= 1'b0;
      end
   end
`else
   assign in_ready  = !out_valid || out_ready || flush;
   assign accept    = in_valid && in_ready;
   assign src_beat  = in_beat;
   assign src_valid = accept;
`endif

   // Output register; flush wins over any transfer but leaves the data fields alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_beat    <= '0;
         out_reg_en  <= 1'b0;
         out_wb_data <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         out_reg_en <= 1'b0;
      end else if (load) begin
         out_valid  <= src_valid;
         out_reg_en <= src_valid && src_beat.reg_en;
         if (src_valid) begin
            out_beat    <= src_beat;
            out_wb_data <= src_beat.data_sel ? src_beat.dm : src_beat.alu;
         end
      end
   end

   assign out_dm       = out_beat.dm;
   assign out_alu      = out_beat.alu;
   assign out_ra       = out_beat.ra;
   assign out_wb_sel   = out_beat.wb_sel;
   assign out_data_sel = out_beat.data_sel;

   // Back-pressure counter, saturating, deliberately blind to flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_memwb_stage.sv
// Bench for pipeline_memwb_stage: directed steps plus random traffic against a queue-based model.
module tb_pipeline_memwb_stage;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned RA_W   = 2;
   localparam int unsigned CNT_W  = 3;
   localparam int          STALL_MAX = (1 << CNT_W) - 1;
`ifdef MEMWB_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   typedef struct packed {
      logic [DATA_W-1:0] dm;
      logic [DATA_W-1:0] alu;
      logic [RA_W-1:0]   ra;
      logic              wb_sel;
      logic              data_sel;
      logic              reg_en;
   } tbeat_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_dm = '0;
   logic [DATA_W-1:0] in_alu = '0;
   logic [RA_W-1:0]   in_ra = '0;
   logic              in_wb_sel = 1'b0;
   logic              in_data_sel = 1'b0;
   logic              in_reg_en = 1'b0;
   logic              flush = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_dm;
   logic [DATA_W-1:0] out_alu;
   logic [RA_W-1:0]   out_ra;
   logic              out_wb_sel;
   logic              out_data_sel;
   logic              out_reg_en;
   logic [DATA_W-1:0] out_wb_data;
   logic [CNT_W-1:0]  stall_cnt;

   pipeline_memwb_stage #(.DATA_W(DATA_W), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_dm(in_dm), .in_alu(in_alu), .in_ra(in_ra), .in_wb_sel(in_wb_sel),
      .in_data_sel(in_data_sel), .in_reg_en(in_reg_en), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_dm(out_dm), .out_alu(out_alu),
      .out_ra(out_ra), .out_wb_sel(out_wb_sel), .out_data_sel(out_data_sel),
      .out_reg_en(out_reg_en), .out_wb_data(out_wb_data), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int     tests = 0;
   int     fails = 0;
   tbeat_t q[$];
   tbeat_t last_out = '0;
   int     exp_stall = 0;
   bit     pushed;
   logic [DATA_W-1:0] got[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit exp_ready();
      if (CAP == 2) return q.size() < 2;
      return (q.size() == 0) || out_ready || flush;
   endfunction

   task automatic check_outputs();
      bit v;
      v = q.size() > 0;
      chk("out_valid", 32'(out_valid), 32'(v));
      chk("out_dm", 32'(out_dm), 32'(last_out.dm));
      chk("out_alu", 32'(out_alu), 32'(last_out.alu));
      chk("out_ra", 32'(out_ra), 32'(last_out.ra));
      chk("out_wb_sel", 32'(out_wb_sel), 32'(last_out.wb_sel));
      chk("out_data_sel", 32'(out_data_sel), 32'(last_out.data_sel));
      chk("out_wb_data", 32'(out_wb_data),
          32'(last_out.data_sel ? last_out.dm : last_out.alu));
      chk("out_reg_en", 32'(out_reg_en), 32'(v && last_out.reg_en));
      chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
   endtask

   // One clock: check in_ready, advance the model across the edge, check outputs.
   task automatic tick();
      tbeat_t b;
      bit rdy, pop, stall_inc;
      #1;
      rdy = exp_ready();
      if (!rst) chk("in_ready", 32'(in_ready), 32'(rdy));
      b = {in_dm, in_alu, in_ra, in_wb_sel, in_data_sel, in_reg_en};
      pop = (q.size() > 0) && out_ready;
      pushed = in_valid && rdy && !flush && !rst;
      stall_inc = (q.size() > 0) && !out_ready;
      if (out_valid === 1'b1 && out_ready && !rst) got.push_back(out_dm);
      @(posedge clk);
      if (rst) begin
         q.delete();
         exp_stall = 0;
         last_out = '0;
      end else begin
         if (stall_inc && exp_stall < STALL_MAX) exp_stall++;
         if (flush) q.delete();
         else begin
            if (pop) void'(q.pop_front());
            if (pushed) q.push_back(b);
         end
         if (q.size() > CAP) begin
            tests++; fails++;
            $error("FAIL model_overflow observed=%0d expected<=%0d", q.size(), CAP);
         end
         if (q.size() > 0) last_out = q[0];
      end
      #1;
      check_outputs();
   endtask

   task automatic drive(input bit v, input logic [7:0] dm, input logic [7:0] alu,
                        input logic [1:0] ra, input bit wbs, input bit dsel, input bit ren);
      in_valid = v; in_dm = dm; in_alu = alu; in_ra = ra;
      in_wb_sel = wbs; in_data_sel = dsel; in_reg_en = ren;
   endtask

   task automatic drive_rand(input bit v);
      drive(v, 8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
   endtask

   initial begin
      int i, budget;
      // Reset held two cycles: everything zero.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("ready_after_rst", 32'(in_ready), 32'd1);

      // Basic write-back of memory data.
      drive(1, 8'hA5, 8'h3C, 2'd2, 0, 1, 1);
      tick();
      drive(0, 8'h00, 8'h00, 2'd0, 0, 0, 0);
      chk("wb_valid", 32'(out_valid), 32'd1);
      chk("wb_data_A5", 32'(out_wb_data), 32'hA5);
      chk("wb_ra", 32'(out_ra), 32'd2);
      chk("wb_reg_en", 32'(out_reg_en), 32'd1);
      tick();
      tick();

      // Five stalled cycles with a beat held and another waiting.
      drive(1, 8'h11, 8'h71, 2'd1, 1, 0, 1);
      tick();
      drive(1, 8'h22, 8'h72, 2'd3, 0, 1, 1);
      out_ready = 1'b0;
      repeat (5) tick();
      chk("stall_5", 32'(stall_cnt), 32'd5);
      chk("stall_hold_alu", 32'(out_alu), 32'h71);
      chk("stall_ready", 32'(in_ready), 32'(0));
      drive(0, 8'h00, 8'h00, 2'd0, 0, 0, 0);
      out_ready = 1'b1;
      repeat (3) tick();

      // Flush with a held beat and a beat on the input.
      drive(1, 8'h33, 8'h73, 2'd1, 0, 1, 1);
      tick();
      drive(1, 8'h34, 8'h74, 2'd2, 0, 1, 1);
      out_ready = 1'b0;
      tick();
      drive(1, 8'h44, 8'h84, 2'd3, 0, 1, 1);
      flush = 1'b1;
      got.delete();
      tick();
      flush = 1'b0;
      drive(0, 8'h00, 8'h00, 2'd0, 0, 0, 0);
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_reg_en", 32'(out_reg_en), 32'd0);
      out_ready = 1'b1;
      repeat (4) tick();
      chk("flush_no_beats", 32'(got.size()), 32'd0);

      // Saturation of a 3-bit counter over ten stalled cycles.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1, 8'h55, 8'h66, 2'd1, 0, 0, 1);
      tick();
      drive(0, 8'h00, 8'h00, 2'd0, 0, 0, 0);
      out_ready = 1'b0;
      repeat (10) tick();
      chk("stall_sat", 32'(stall_cnt), 32'd7);
      tick();
      chk("stall_sat_hold", 32'(stall_cnt), 32'd7);
      out_ready = 1'b1;
      repeat (2) tick();

      // Stream beats 1..8 under random back-pressure; order must be preserved.
      got.delete();
      i = 1;
      budget = 0;
      while ((got.size() < 8) && (budget < 300)) begin
         if (i <= 8) drive(1, 8'(i), 8'($urandom), 2'($urandom), 1'($urandom), 1, 1'($urandom));
         else drive(0, 8'h00, 8'h00, 2'd0, 0, 0, 0);
         out_ready = 1'($urandom_range(0, 1));
         tick();
         if (pushed) i++;
         budget++;
      end
      chk("stream_count", 32'(got.size()), 32'd8);
      for (int k = 0; k < got.size(); k++) chk("stream_order", 32'(got[k]), 32'(k + 1));

      // Random traffic with occasional flush and reset.
      drive(0, 8'h00, 8'h00, 2'd0, 0, 0, 0);
      for (int n = 0; n < 400; n++) begin
         drive_rand(1'($urandom_range(0, 3) != 0));
         out_ready = 1'($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 19) == 0);
         rst = ($urandom_range(0, 79) == 0);
         tick();
      end
      rst = 1'b0;
      flush = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pipeline_memwb_stage.md
PIPELINE_MEMWB_STAGE -- requirements
Module: pipeline_memwb_stage

Interface
REQ-001 Parameter DATA_W, default 8, width of the memory-data and ALU/effective-address paths.
REQ-002 Parameter RA_W, default 2, width of the destination register address.
REQ-003 Parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream MEM stage holds a valid beat.
REQ-007 in_ready  output  1  stage accepts the beat this cycle.
REQ-008 in_dm / in_alu  input  DATA_W each  memory read data and ALU result/effective address.
REQ-009 in_ra  input  RA_W  destination register address.
REQ-010 in_wb_sel, in_data_sel, in_reg_en  input  1 each  write-back control bits.
REQ-011 flush  input  1  kill all held and incoming beats.
REQ-012 out_valid  output  1  write-back beat valid.
REQ-013 out_ready  input  1  downstream consumes the beat this cycle.
REQ-014 out_dm, out_alu, out_ra, out_wb_sel, out_data_sel  output  matching widths  registered copies of the accepted beat.
REQ-015 out_reg_en  output  1  registered in_reg_en ANDed with out_valid.
REQ-016 out_wb_data  output  DATA_W  registered result: in_dm when in_data_sel=1, else in_alu.
REQ-017 stall_cnt  output  CNT_W  count of back-pressured cycles.

Function
REQ-018 Input transfer SHALL occur when in_valid and in_ready are both 1; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-019 Latency SHALL be exactly 1 cycle from input transfer to out_valid=1 when the output register is empty or draining.
REQ-020 The output register SHALL load when out_valid=0 or out_ready=1; otherwise all out_* fields SHALL hold.
REQ-021 out_valid SHALL fall after an output transfer with no new beat available.
REQ-022 Beats SHALL leave in acceptance order, with no duplication and no loss except by flush.
REQ-023 flush=1 SHALL clear out_valid (and skid, if present) at the next edge and SHALL raise in_ready; the beat presented that cycle SHALL be discarded.
REQ-024 flush SHALL take priority over a simultaneous input or output transfer.
REQ-025 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, saturating at 2^CNT_W-1 with no wrap.
REQ-026 stall_cnt SHALL be unaffected by flush.
REQ-027 Data fields SHALL never be X-dependent for control: out_reg_en SHALL be 0 whenever out_valid=0.

Reset
REQ-028 rst=1 at a rising edge SHALL zero out_valid, every out_* field, out_wb_data, stall_cnt and the skid entry.
REQ-029 rst SHALL override flush and all transfers; a beat in flight is dropped.
REQ-030 The first accept SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-031 Macro MEMWB_SKID_EN SHALL add a one-entry skid buffer in front of the output register.
REQ-032 Defined: in_ready SHALL be a registered signal, equal to NOT skid_valid; a beat accepted while the output is stalled goes to skid and moves to the output on the next output transfer; throughput 1 beat/cycle.
REQ-033 Undefined: no skid storage; in_ready SHALL equal (NOT out_valid) OR out_ready OR flush, combinationally.

Verification
REQ-034 rst for 2 cycles -> all outputs 0, stall_cnt=0; in_ready=1 after release.
REQ-035 Accept in_dm=0xA5, in_alu=0x3C, in_data_sel=1, in_ra=2, in_reg_en=1, with out_ready=1 -> next cycle out_valid=1, out_wb_data=0xA5, out_ra=2, out_reg_en=1.
REQ-036 Hold out_ready=0 for 5 cycles with a valid beat -> outputs stable and stall_cnt=5; with MEMWB_SKID_EN, exactly one more beat is accepted, then in_ready=0.
REQ-037 Stream beats 1..8 with random out_ready -> the beats 1..8 arrive in order with no gaps or duplicates.
REQ-038 Assert flush with a beat held and in_valid=1 -> next cycle out_valid=0, out_reg_en=0, and neither beat ever appears.
REQ-039 With CNT_W=3, stall for 10 cycles -> stall_cnt reads 7 and holds.
